// File: rtl/axis_ts_pkg.sv
// Shared definitions for the timestamp prepend/strip stages: FSM state encoding,
// endianness constants and the header-beat count helper.
package axis_ts_pkg;

    typedef enum logic {
        ST_HDR = 1'b0,
        ST_PAY = 1'b1
    } ts_state_e;

    localparam bit TS_BIG_ENDIAN    = 1'b0;
    localparam bit TS_LITTLE_ENDIAN = 1'b1;

    function automatic int hdr_beats(input int value_w, input int data_w);
        return value_w / data_w;
    endfunction

endpackage

// File: rtl/axis_ts_out_reg.sv
// Single AXI4-Stream register slice carrying data/keep/last/user/valid on the payload path.
module axis_ts_out_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [KEEP_WIDTH-1:0] i_keep,
    input  logic                  i_last,
    input  logic [USER_WIDTH-1:0] i_user,
    input  logic                  i_ready,
    output logic                  o_can_load,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [KEEP_WIDTH-1:0] o_keep,
    output logic                  o_valid,
    output logic                  o_last,
    output logic [USER_WIDTH-1:0] o_user
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_valid;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;

    // A new beat may enter when the slot is empty or is being drained this cycle.
    assign o_can_load = i_ready | ~r_valid;

    // Slot storage: load on accept, clear valid once the consumer takes it, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_user  <= '0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_user  <= i_user;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_user  = r_user;

endmodule

// File: rtl/axis_ts_strip.sv
// Strips the timestamp prefix from each AXI4-Stream frame into value_out and forwards the payload.
// Optional frame/truncation statistics are built when AXIS_TS_STRIP_STATS_EN is defined.
module axis_ts_strip
    import axis_ts_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int VALUE_WIDTH   = 32,
    parameter int USER_WIDTH    = 1,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   value_valid,
    output logic                   trunc_err,
    output logic [31:0]            frame_cnt,
    output logic [31:0]            trunc_cnt
);

    localparam int HDR_BEATS = hdr_beats(VALUE_WIDTH, DATA_WIDTH);
    localparam int CNT_W     = $clog2(HDR_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HDR_BEATS - 1);

    if (((VALUE_WIDTH % DATA_WIDTH) != 0) || (VALUE_WIDTH < DATA_WIDTH)) begin : g_bad_width
        $error("axis_ts_strip: VALUE_WIDTH must be a non-zero multiple of DATA_WIDTH");
    end

    ts_state_e              r_state;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [VALUE_WIDTH-1:0] r_shadow;
    logic [VALUE_WIDTH-1:0] r_value;
    logic                   r_value_valid;
    logic                   r_trunc_err;

    logic                   w_s_ready;
    logic                   w_s_fire;
    logic                   w_out_can_load;
    logic                   w_pay_load;
    logic [CNT_W-1:0]       w_slice_idx;
    logic [VALUE_WIDTH-1:0] w_shadow_next;

    // Header capture never waits on the output side; payload only moves when the slot frees up.
    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            ST_HDR:  w_s_ready = 1'b1;
            ST_PAY:  w_s_ready = w_out_can_load;
            default: w_s_ready = 1'b0;
        endcase
    end

    assign w_s_fire   = s_axis_tvalid & w_s_ready;
    assign w_pay_load = w_s_fire & (r_state == ST_PAY);

    assign w_slice_idx = (LITTLE_ENDIAN == TS_LITTLE_ENDIAN) ? r_beat_cnt : (LAST_BEAT - r_beat_cnt);

    // Shadow including the beat on the bus, so the final header beat publishes in the same edge.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int b = 0; b < HDR_BEATS; b++) begin
            if (w_slice_idx == CNT_W'(b)) begin
                w_shadow_next[b*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
            end else begin
                w_shadow_next[b*DATA_WIDTH +: DATA_WIDTH] = r_shadow[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Frame FSM: header collection, value publication, truncation detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_HDR;
            r_beat_cnt    <= '0;
            r_shadow      <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_trunc_err   <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            r_trunc_err   <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_s_fire) begin
                        r_shadow <= w_shadow_next;
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_value       <= w_shadow_next;
                            r_value_valid <= 1'b1;
                            r_beat_cnt    <= '0;
                            r_state       <= s_axis_tlast ? ST_HDR : ST_PAY;
                        end else if (s_axis_tlast) begin
                            r_trunc_err <= 1'b1;
                            r_beat_cnt  <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PAY: begin
                    if (w_s_fire && s_axis_tlast) begin
                        r_state <= ST_HDR;
                    end
                end
                default: begin
                    r_state    <= ST_HDR;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    axis_ts_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pay_load),
        .i_data     (s_axis_tdata),
        .i_keep     (s_axis_tkeep),
        .i_last     (s_axis_tlast),
        .i_user     (s_axis_tuser),
        .i_ready    (m_axis_tready),
        .o_can_load (w_out_can_load),
        .o_data     (m_axis_tdata),
        .o_keep     (m_axis_tkeep),
        .o_valid    (m_axis_tvalid),
        .o_last     (m_axis_tlast),
        .o_user     (m_axis_tuser)
    );

    assign s_axis_tready = w_s_ready;
    assign value_out     = r_value;
    assign value_valid   = r_value_valid;
    assign trunc_err     = r_trunc_err;

`ifdef AXIS_TS_STRIP_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [31:0] r_trunc_cnt;

    // Wrapping statistics counters driven by the published pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 32'd0;
            r_trunc_cnt <= 32'd0;
        end else begin
            r_frame_cnt <= r_value_valid ? (r_frame_cnt + 32'd1) : r_frame_cnt;
            r_trunc_cnt <= r_trunc_err   ? (r_trunc_cnt + 32'd1) : r_trunc_cnt;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign trunc_cnt = r_trunc_cnt;
`else
    assign frame_cnt = 32'd0;
    assign trunc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_axis_ts_strip.sv
// Randomized, scoreboard-checked bench for axis_ts_strip; one LE and one BE instance share stimulus.
`timescale 1ns/1ps
module tb_axis_ts_strip;

`ifdef AXIS_TS_STRIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic [0:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic        m_ready;
    logic        rand_ready = 1'b0;

    logic        s_tready0, s_tready1;
    logic [7:0]  m_tdata0, m_tdata1;
    logic [0:0]  m_tkeep0, m_tkeep1;
    logic        m_tvalid0, m_tvalid1;
    logic        m_tlast0, m_tlast1;
    logic [0:0]  m_tuser0, m_tuser1;
    logic [31:0] value_out0, value_out1;
    logic        value_valid0, value_valid1;
    logic        trunc_err0, trunc_err1;
    logic [31:0] frame_cnt0, frame_cnt1, trunc_cnt0, trunc_cnt1;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_truncs = 0;
    int beats_seen = 0;
    int mvalid_cycles = 0;

    // Model: expected payload beats {last,user,keep,data} and events {is_trunc,value} per instance
    logic [10:0] pq0[$], pq1[$];
    logic [32:0] eq0[$], eq1[$];
    logic        stall_v[2];
    logic [10:0] stall_d[2];

    logic [7:0]  fbuf[0:127];
    logic [0:0]  fkeep[0:127];
    logic [0:0]  fuser[0:127];
    int          flen;

    always #5 clk = ~clk;

    axis_ts_strip #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .VALUE_WIDTH(32), .USER_WIDTH(1), .LITTLE_ENDIAN(1'b1)) u_le (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_ready),
        .m_axis_tlast(m_tlast0), .m_axis_tuser(m_tuser0),
        .value_out(value_out0), .value_valid(value_valid0), .trunc_err(trunc_err0),
        .frame_cnt(frame_cnt0), .trunc_cnt(trunc_cnt0)
    );

    axis_ts_strip #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .VALUE_WIDTH(32), .USER_WIDTH(1), .LITTLE_ENDIAN(1'b0)) u_be (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_ready),
        .m_axis_tlast(m_tlast1), .m_axis_tuser(m_tuser1),
        .value_out(value_out1), .value_valid(value_valid1), .trunc_err(trunc_err1),
        .frame_cnt(frame_cnt1), .trunc_cnt(trunc_cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_side(input int d, input logic mv, input logic [10:0] mbus,
                              input logic vv, input logic [31:0] vo, input logic te);
        logic [10:0] ep;
        logic [32:0] ee;
        int          qs;
        if (stall_v[d]) begin
            chk($sformatf("stall_valid%0d", d), 64'(mv), 64'd1);
            chk($sformatf("stall_data%0d", d), 64'(mbus), 64'(stall_d[d]));
        end
        stall_v[d] = mv && !m_ready;
        stall_d[d] = mbus;
        if (mv && m_ready) begin
            qs = (d == 0) ? pq0.size() : pq1.size();
            if (qs == 0) begin
                chk($sformatf("spurious_beat%0d", d), 64'(mbus), 64'h7ff);
            end else begin
                ep = (d == 0) ? pq0.pop_front() : pq1.pop_front();
                chk($sformatf("payload%0d", d), 64'(mbus), 64'(ep));
                if (d == 0) beats_seen++;
            end
        end
        if (vv || te) begin
            qs = (d == 0) ? eq0.size() : eq1.size();
            if (qs == 0) begin
                chk($sformatf("spurious_event%0d", d), {62'd0, vv, te}, 64'd0);
            end else begin
                ee = (d == 0) ? eq0.pop_front() : eq1.pop_front();
                chk($sformatf("event_kind%0d", d), {62'd0, vv, te}, ee[32] ? 64'd1 : 64'd2);
                if (!ee[32]) chk($sformatf("value%0d", d), 64'(vo), 64'(ee[31:0]));
            end
        end
    endtask

    // Compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        if (rst) begin
            pq0.delete(); pq1.delete(); eq0.delete(); eq1.delete();
            stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        end else begin
            if (m_tvalid0) mvalid_cycles++;
            check_side(0, m_tvalid0, {m_tlast0, m_tuser0, m_tkeep0, m_tdata0}, value_valid0, value_out0, trunc_err0);
            check_side(1, m_tvalid1, {m_tlast1, m_tuser1, m_tkeep1, m_tdata1}, value_valid1, value_out1, trunc_err1);
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [0:0] k, input logic l, input logic [0:0] u);
        bit ok = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        for (int g = 0; g < 2000 && !ok; g++) begin
            @(negedge clk);
            ok = s_tready0;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL s_tready_timeout: got 0 expected 1");
        end
        s_tvalid = 1'b0;
    endtask

    task automatic set_frame(input logic [63:0] bytes_msb_first, input int n);
        flen = n;
        for (int i = 0; i < n; i++) fbuf[i] = bytes_msb_first[(n-1-i)*8 +: 8];
    endtask

    // Pushes the expected outcome of the loaded frame, then drives its first nsend beats.
    task automatic send_frame(input int nsend);
        logic [31:0] le, be;
        for (int i = 0; i < flen; i++) begin
            fkeep[i] = 1'($urandom_range(0, 1));
            fuser[i] = 1'($urandom_range(0, 1));
        end
        if (flen < 4) begin
            eq0.push_back({1'b1, 32'd0});
            eq1.push_back({1'b1, 32'd0});
            exp_truncs++;
        end else begin
            le = {fbuf[3], fbuf[2], fbuf[1], fbuf[0]};
            be = {fbuf[0], fbuf[1], fbuf[2], fbuf[3]};
            eq0.push_back({1'b0, le});
            eq1.push_back({1'b0, be});
            exp_frames++;
            for (int i = 4; i < flen; i++) begin
                pq0.push_back({(i == flen - 1), fuser[i], fkeep[i], fbuf[i]});
                pq1.push_back({(i == flen - 1), fuser[i], fkeep[i], fbuf[i]});
            end
        end
        for (int i = 0; i < nsend; i++) begin
            if (rand_ready && ($urandom_range(0, 3) == 0)) begin
                @(posedge clk); #1;
            end
            send_beat(fbuf[i], fkeep[i], (i == flen - 1), fuser[i]);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk); #2;
            if (pq0.size() == 0 && pq1.size() == 0 && eq0.size() == 0 && eq1.size() == 0 &&
                !m_tvalid0 && !m_tvalid1) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_drain: got busy expected idle", tag);
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_frame_cnt_le"}, 64'(frame_cnt0), STATS ? 64'(exp_frames) : 64'd0);
        chk({tag, "_frame_cnt_be"}, 64'(frame_cnt1), STATS ? 64'(exp_frames) : 64'd0);
        chk({tag, "_trunc_cnt_le"}, 64'(trunc_cnt0), STATS ? 64'(exp_truncs) : 64'd0);
        chk({tag, "_trunc_cnt_be"}, 64'(trunc_cnt1), STATS ? 64'(exp_truncs) : 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_m_valid_le"}, 64'(m_tvalid0), 64'd0);
        chk({tag, "_m_valid_be"}, 64'(m_tvalid1), 64'd0);
        chk({tag, "_m_data_le"}, 64'(m_tdata0), 64'd0);
        chk({tag, "_value_le"}, 64'(value_out0), 64'd0);
        chk({tag, "_value_be"}, 64'(value_out1), 64'd0);
        chk({tag, "_pulses"}, {60'd0, value_valid0, value_valid1, trunc_err0, trunc_err1}, 64'd0);
        chk({tag, "_s_ready_le"}, 64'(s_tready0), 64'd1);
        chk({tag, "_s_ready_be"}, 64'(s_tready1), 64'd1);
        check_counters(tag);
    endtask

    initial begin
        int b0;
        int mv0;
        int r;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'd0; s_tkeep = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;

        // Basic frame, both endiannesses
        b0 = beats_seen;
        set_frame(64'h78563412AABBCC, 7);
        send_frame(7);
        wait_idle("t1");
        chk("t1_value_le", 64'(value_out0), 64'h12345678);
        chk("t1_value_be", 64'(value_out1), 64'h78563412);
        chk("t1_beats", 64'(beats_seen - b0), 64'd3);

        // Truncated frame leaves value_out untouched, next frame decodes
        set_frame(64'h0102, 2);
        send_frame(2);
        wait_idle("t3a");
        chk("t3_value_kept", 64'(value_out0), 64'h12345678);
        set_frame(64'h1122334455, 5);
        send_frame(5);
        wait_idle("t3b");
        chk("t3_value_le", 64'(value_out0), 64'h44332211);
        chk("t3_value_be", 64'(value_out1), 64'h11223344);

        // Header-only frame
        mv0 = mvalid_cycles;
        set_frame(64'h01020304, 4);
        send_frame(4);
        wait_idle("t4");
        chk("t4_value_le", 64'(value_out0), 64'h04030201);
        chk("t4_no_payload", 64'(mvalid_cycles - mv0), 64'd0);
        check_counters("directed");

        // Random back-pressure, back-to-back frames
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       flen = $urandom_range(1, 3);
            else if (r < 13) flen = 4;
            else             flen = 4 + $urandom_range(1, 64);
            for (int i = 0; i < flen; i++) fbuf[i] = 8'($urandom_range(0, 255));
            send_frame(flen);
        end
        wait_idle("t5");
        rand_ready = 1'b0;
        check_counters("random");

        // Reset in the middle of a payload
        flen = 20;
        for (int i = 0; i < flen; i++) fbuf[i] = 8'($urandom_range(0, 255));
        send_frame(8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_frames = 0;
        exp_truncs = 0;
        @(negedge clk);
        check_reset_state("t6_reset");
        @(posedge clk); #1;
        set_frame(64'hA1B2C3D4EEFF, 6);
        send_frame(6);
        wait_idle("t6");
        chk("t6_value_le", 64'(value_out0), 64'hD4C3B2A1);
        chk("t6_value_be", 64'(value_out1), 64'hA1B2C3D4);
        check_counters("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
